// File: rtl/buffer_pkg.sv
// Shared constants and helpers for the buffer delay line.
package buffer_pkg;

    localparam int MAX_STAGES = 16;

    // Width of the saturating fill counter; never narrower than one bit.
    function automatic int fill_cnt_width(input int stages);
        return (stages < 1) ? 1 : $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/buffer_stage.sv
// One WIDTH-bit delay register, cleared asynchronously to zero.
// Latency 1 cycle; it has no stall and loads on every edge.
module buffer_stage #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else     q <= d;
    end

endmodule

// File: rtl/buffer.sv
// Fixed-latency delay line (STAGES cycles, 0 = wire) with a fill flag; it has no stall.
// Optional per-bit rise/fall pulses on y when BUFFER_EDGE_DET_EN is defined.
module buffer
    import buffer_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
`ifdef BUFFER_EDGE_DET_EN
    ,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`endif
);

    if (WIDTH < 1 || WIDTH > 64 || STAGES < 0 || STAGES > MAX_STAGES) begin : g_param_err
        $error("buffer: WIDTH must be 1..64 and STAGES 0..MAX_STAGES");
    end

    if (STAGES == 0) begin : g_wire
        assign y       = a;
        assign y_valid = 1'b1;
    end else begin : g_pipe
        localparam int CW = fill_cnt_width(STAGES);

        logic [WIDTH-1:0] chain [0:STAGES];
        logic [CW-1:0]    fill_cnt;

        assign chain[0] = a;

        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            buffer_stage #(.WIDTH(WIDTH)) u_stage (
                .clk (clk),
                .rst (rst),
                .d   (chain[k]),
                .q   (chain[k+1])
            );
        end

        // Counts edges since reset until the reset zeros have drained out.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                         fill_cnt <= '0;
            else if (fill_cnt != CW'(STAGES)) fill_cnt <= fill_cnt + 1'b1;
        end

        assign y       = chain[STAGES];
        assign y_valid = (fill_cnt == CW'(STAGES));
    end

`ifdef BUFFER_EDGE_DET_EN
    logic [WIDTH-1:0] y_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) y_d <= '0;
        else     y_d <= y;
    end

    assign rise =  y & ~y_d & {WIDTH{y_valid}};
    assign fall = ~y &  y_d & {WIDTH{y_valid}};
`endif

endmodule

// File: tb/tb_buffer.sv
// Bench for buffer: three instances (1-bit/2-stage, 8-bit/3-stage, 8-bit pass-through)
// compared every cycle against a queue-based history model.
module tb_buffer;

    logic       clk;
    logic       rst;
    logic       a0, y0, v0;
    logic [7:0] a1, y1, a2, y2;
    logic       v1, v2;
`ifdef BUFFER_EDGE_DET_EN
    logic       r0, f0;
    logic [7:0] r1, f1, r2, f2;
`endif

    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    buffer #(.WIDTH(1), .STAGES(2)) u_dut0 (
        .clk(clk), .rst(rst), .a(a0), .y(y0), .y_valid(v0)
`ifdef BUFFER_EDGE_DET_EN
        , .rise(r0), .fall(f0)
`endif
    );

    buffer #(.WIDTH(8), .STAGES(3)) u_dut1 (
        .clk(clk), .rst(rst), .a(a1), .y(y1), .y_valid(v1)
`ifdef BUFFER_EDGE_DET_EN
        , .rise(r1), .fall(f1)
`endif
    );

    buffer #(.WIDTH(8), .STAGES(0)) u_dut2 (
        .clk(clk), .rst(rst), .a(a2), .y(y2), .y_valid(v2)
`ifdef BUFFER_EDGE_DET_EN
        , .rise(r2), .fall(f2)
`endif
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, want, $time);
        end
    endtask

    // Reference model: history of values accepted since reset; output is the one STAGES back.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] yd0 = '0, yd1 = '0, yd2 = '0;

    function automatic logic [7:0] ey0();
        return (q0.size() >= 2) ? q0[q0.size()-2] : 8'h00;
    endfunction

    function automatic logic [7:0] ey1();
        return (q1.size() >= 3) ? q1[q1.size()-3] : 8'h00;
    endfunction

    function automatic logic ev0();
        return q0.size() >= 2;
    endfunction

    function automatic logic ev1();
        return q1.size() >= 3;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            yd0 = ey0();
            yd1 = ey1();
            yd2 = a2;
            q0.push_back({7'b0, a0});
            q1.push_back(a1);
            if (q0.size() > 4) void'(q0.pop_front());
            if (q1.size() > 4) void'(q1.pop_front());
        end
    end

    always @(posedge rst) begin
        q0.delete();
        q1.delete();
        yd0 = '0;
        yd1 = '0;
        yd2 = '0;
    end

    task automatic check_outputs();
        check("y0", {7'b0, y0}, ey0());
        check("v0", {7'b0, v0}, {7'b0, ev0()});
        check("y1", y1, ey1());
        check("v1", {7'b0, v1}, {7'b0, ev1()});
        check("y2", y2, a2);
        check("v2", {7'b0, v2}, 8'h01);
`ifdef BUFFER_EDGE_DET_EN
        check("rise0", {7'b0, r0}, ey0() & ~yd0 & {8{ev0()}} & 8'h01);
        check("fall0", {7'b0, f0}, ~ey0() & yd0 & {8{ev0()}} & 8'h01);
        check("rise1", r1, ey1() & ~yd1 & {8{ev1()}});
        check("fall1", f1, ~ey1() & yd1 & {8{ev1()}});
        check("rise2", r2, a2 & ~yd2);
        check("fall2", f2, ~a2 & yd2);
`endif
    endtask

    initial begin
        rst = 1'b1;
        a0  = 1'b1;
        a1  = 8'hA5;
        a2  = 8'h3C;
        #1;
        check("rst_y0", {7'b0, y0}, 8'h00);
        check("rst_v0", {7'b0, v0}, 8'h00);
        check("rst_y1", y1, 8'h00);
        check("rst_v1", {7'b0, v1}, 8'h00);
        check("rst_y2", y2, 8'h3C);
        check("rst_v2", {7'b0, v2}, 8'h01);
        @(negedge clk);
        check_outputs();
        @(negedge clk);
        check_outputs();
        @(negedge clk);
        rst = 1'b0;

        for (int c = 0; c < 98; c++) begin
            if (c > 0) @(negedge clk);
            check_outputs();
            if (c == 35) begin
                check("mid_pre_y0", {7'b0, y0}, 8'h01);
                rst = 1'b1;
                #1;
                check("mid_y0", {7'b0, y0}, 8'h00);
                check("mid_v0", {7'b0, v0}, 8'h00);
                check("mid_y1", y1, 8'h00);
                check("mid_v1", {7'b0, v1}, 8'h00);
                check("mid_v2", {7'b0, v2}, 8'h01);
                #2;
                rst = 1'b0;
            end
            a0 = 1'(((c + 1) / 10) % 2);
            a1 = 8'($urandom);
            a2 = 8'($urandom);
            #1;
            check("pass_y2", y2, a2);
`ifdef BUFFER_EDGE_DET_EN
            check("pass_rise2", r2, a2 & ~yd2);
            check("pass_fall2", f2, ~a2 & yd2);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
